ram_dual_port_rigel: RTL and testbench

- Parametrised single-clock true dual-port RAM for Rigel line buffers and LUTs.
- Successor to the fixed 16 Kbit RAMB16-style model. Adds:
  - arbitrary width and depth;
  - byte-lane write enables;
  - a per-port write mode;
  - an optional output register;
  - hardware clear after reset, with a ready flag;
  - deterministic same-address collision resolution and reporting.

---
 rtl/ram_dual_port_rigel.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_ram_dual_port_rigel.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dual_port_rigel.sv
// rtl/ram_dual_port_rigel.sv - parametrised single-clock true dual-port RAM with clear, byte lanes and collision handling
//
// Purpose:
//   Two independent request ports (A and B) share one memory array and one clock.
//   After reset the array is optionally filled with CLEAR_VALUE, one word per cycle,
//   and requests are only accepted once ready is high. Each port has its own write
//   mode. Same-address conflicts with at least one writer are resolved
//   deterministically (B wins overlapped lanes) and reported.
//
// Ports:
//   CLK              single clock for both ports
//   reset            asynchronous, active-high
//   ready            high once the post-reset clear has finished
//   ENA / ENB        port request
//   WEA / WEB        lane write enables (all zero = read)
//   ADDRA / ADDRB    word address
//   DIA / DIB        write data
//   DOA / DOB        read data, held between valid pulses
//   VALIDA / VALIDB  one-cycle pulse: DOx holds the result of an accepted request
//   collision        one-cycle pulse for a same-address conflict
//   collision_count  saturating number of conflicts since reset

module ram_dual_port_rigel #(
  parameter int              BITS           = 8,
  parameter int              DEPTH          = 2048,
  parameter string           WRITE_MODE_A   = "write_first",
  parameter string           WRITE_MODE_B   = "write_first",
  parameter int              OUTPUT_REG     = 0,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [BITS-1:0] CLEAR_VALUE    = '0,
  localparam int             LANES          = (BITS < 8) ? 1 : BITS / 8,
  localparam int             AW             = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             reset,
  output logic             ready,
  input  logic             ENA,
  input  logic [LANES-1:0] WEA,
  input  logic [AW-1:0]    ADDRA,
  input  logic [BITS-1:0]  DIA,
  output logic [BITS-1:0]  DOA,
  output logic             VALIDA,
  input  logic             ENB,
  input  logic [LANES-1:0] WEB,
  input  logic [AW-1:0]    ADDRB,
  input  logic [BITS-1:0]  DIB,
  output logic [BITS-1:0]  DOB,
  output logic             VALIDB,
  output logic             collision,
  output logic [15:0]      collision_count
);

  localparam int MODE_WF = 0;
  localparam int MODE_RF = 1;
  localparam int MODE_NC = 2;

  localparam int MODE_A = (WRITE_MODE_A == "read_first") ? MODE_RF :
                          (WRITE_MODE_A == "no_change")  ? MODE_NC : MODE_WF;
  localparam int MODE_B = (WRITE_MODE_B == "read_first") ? MODE_RF :
                          (WRITE_MODE_B == "no_change")  ? MODE_NC : MODE_WF;

  // One extra bit so a power-of-two DEPTH still compares correctly.
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [AW-1:0]   clr_addr;
  logic            clr_we;
  logic            clr_last;

  logic [BITS-1:0] mem [0:DEPTH-1];

  logic [BITS-1:0] mask_a;
  logic [BITS-1:0] mask_b;

  logic            acc_a;
  logic            acc_b;
  logic            wr_a;
  logic            wr_b;
  logic            in_a;
  logic            in_b;
  logic            coll;
  logic [BITS-1:0] old_a;
  logic [BITS-1:0] old_b;
  logic [BITS-1:0] new_a;
  logic [BITS-1:0] base_b;
  logic [BITS-1:0] new_b;
  logic            mem_we_a;
  logic            mem_we_b;
  logic            emit_a;
  logic            emit_b;
  logic [BITS-1:0] ret_a;
  logic [BITS-1:0] ret_b;

  logic            s1_valid_a;
  logic            s1_valid_b;
  logic [BITS-1:0] s1_data_a;
  logic [BITS-1:0] s1_data_b;

  // ---------------------------------------------------------------------------
  // Control FSM: CLEAR walks the array once, then RUN for good.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_CLEAR && clr_last) begin
      state_next = ST_RUN;
    end
  end

  always_comb begin
    ready  = (state == ST_RUN);
    clr_we = (state == ST_CLEAR);
  end

  assign clr_last = (clr_addr == LAST_ADDR);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      clr_addr <= '0;
    end else if (clr_we) begin
      clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane enables expanded to bit masks. Narrow words use a single lane.
  // ---------------------------------------------------------------------------
  if (BITS < 8) begin : g_narrow
    assign mask_a = {BITS{WEA[0]}};
    assign mask_b = {BITS{WEB[0]}};
  end else begin : g_lanes
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign mask_a[8*k +: 8] = {8{WEA[k]}};
      assign mask_b[8*k +: 8] = {8{WEB[k]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Request datapath.
  // On a collision port B writes the fully merged word (A's lanes first, then
  // B's on top) and port A's own write is suppressed, so the array only ever
  // sees one write per address per cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_a    = ENA & ready;
    acc_b    = ENB & ready;
    wr_a     = acc_a & (|WEA);
    wr_b     = acc_b & (|WEB);
    in_a     = ({1'b0, ADDRA} < DEPTH_W);
    in_b     = ({1'b0, ADDRB} < DEPTH_W);

    old_a    = in_a ? mem[ADDRA] : '0;
    old_b    = in_b ? mem[ADDRB] : '0;

    // in_b is implied by in_a when the addresses match.
    coll     = acc_a & acc_b & in_a & (ADDRA == ADDRB) & (wr_a | wr_b);

    new_a    = (old_a & ~mask_a) | (DIA & mask_a);
    base_b   = coll ? new_a : old_b;
    new_b    = (base_b & ~mask_b) | (DIB & mask_b);

    mem_we_a = wr_a & in_a & ~coll;
    mem_we_b = in_b & (wr_b | coll);

    // A reading port always sees the pre-write word; a writing port follows
    // its mode, and write_first reports the final word actually stored.
    emit_a   = acc_a & ~(wr_a & (MODE_A == MODE_NC));
    emit_b   = acc_b & ~(wr_b & (MODE_B == MODE_NC));

    if (!wr_a || MODE_A == MODE_RF) begin
      ret_a = old_a;
    end else if (!in_a) begin
      ret_a = '0;
    end else if (coll) begin
      ret_a = new_b;
    end else begin
      ret_a = new_a;
    end

    if (!wr_b || MODE_B == MODE_RF) begin
      ret_b = old_b;
    end else if (!in_b) begin
      ret_b = '0;
    end else begin
      ret_b = new_b;
    end
  end

  // Memory array: clear fill during CLEAR, port writes during RUN.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      if (clr_we) begin
        mem[clr_addr] <= CLEAR_VALUE;
      end else begin
        if (mem_we_a) begin
          mem[ADDRA] <= new_a;
        end
        if (mem_we_b) begin
          mem[ADDRB] <= new_b;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First output stage and collision reporting.
  // Data registers only load when a result is emitted, so DOx holds between
  // valid pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s1_valid_a      <= 1'b0;
      s1_valid_b      <= 1'b0;
      s1_data_a       <= '0;
      s1_data_b       <= '0;
      collision       <= 1'b0;
      collision_count <= 16'd0;
    end else begin
      s1_valid_a <= emit_a;
      s1_valid_b <= emit_b;
      if (emit_a) begin
        s1_data_a <= ret_a;
      end
      if (emit_b) begin
        s1_data_b <= ret_b;
      end
      collision <= coll;
      if (coll && collision_count != 16'hFFFF) begin
        collision_count <= collision_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional second output stage.
  // ---------------------------------------------------------------------------
  if (OUTPUT_REG != 0) begin : g_oreg
    logic            s2_valid_a;
    logic            s2_valid_b;
    logic [BITS-1:0] s2_data_a;
    logic [BITS-1:0] s2_data_b;

    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        s2_valid_a <= 1'b0;
        s2_valid_b <= 1'b0;
        s2_data_a  <= '0;
        s2_data_b  <= '0;
      end else begin
        s2_valid_a <= s1_valid_a;
        s2_valid_b <= s1_valid_b;
        if (s1_valid_a) begin
          s2_data_a <= s1_data_a;
        end
        if (s1_valid_b) begin
          s2_data_b <= s1_data_b;
        end
      end
    end

    assign DOA    = s2_data_a;
    assign DOB    = s2_data_b;
    assign VALIDA = s2_valid_a;
    assign VALIDB = s2_valid_b;
  end else begin : g_noreg
    assign DOA    = s1_data_a;
    assign DOB    = s1_data_b;
    assign VALIDA = s1_valid_a;
    assign VALIDB = s1_valid_b;
  end

endmodule

// File: tb/tb_ram_dual_port_rigel.sv
// tb/tb_ram_dual_port_rigel.sv - self-checking bench for ram_dual_port_rigel
module tb_ram_dual_port_rigel;

  localparam int          D  = 100;
  localparam logic [15:0] CV = 16'hA5A5;

  logic        CLK = 1'b0;
  logic        rst   [2];
  logic        rdy   [2];
  logic        ena   [2];
  logic        enb   [2];
  logic [1:0]  wea   [2];
  logic [1:0]  web   [2];
  logic [6:0]  ada   [2];
  logic [6:0]  adb   [2];
  logic [15:0] dia   [2];
  logic [15:0] dib   [2];
  logic [15:0] doa   [2];
  logic [15:0] dob   [2];
  logic        va    [2];
  logic        vb    [2];
  logic        col   [2];
  logic [15:0] ccnt  [2];

  always #5 CLK = ~CLK;

  ram_dual_port_rigel #(
    .BITS(16), .DEPTH(D), .WRITE_MODE_A("write_first"), .WRITE_MODE_B("read_first"),
    .OUTPUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut0 (
    .CLK(CLK), .reset(rst[0]), .ready(rdy[0]),
    .ENA(ena[0]), .WEA(wea[0]), .ADDRA(ada[0]), .DIA(dia[0]), .DOA(doa[0]), .VALIDA(va[0]),
    .ENB(enb[0]), .WEB(web[0]), .ADDRB(adb[0]), .DIB(dib[0]), .DOB(dob[0]), .VALIDB(vb[0]),
    .collision(col[0]), .collision_count(ccnt[0])
  );

  ram_dual_port_rigel #(
    .BITS(16), .DEPTH(D), .WRITE_MODE_A("no_change"), .WRITE_MODE_B("write_first"),
    .OUTPUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut1 (
    .CLK(CLK), .reset(rst[1]), .ready(rdy[1]),
    .ENA(ena[1]), .WEA(wea[1]), .ADDRA(ada[1]), .DIA(dia[1]), .DOA(doa[1]), .VALIDA(va[1]),
    .ENB(enb[1]), .WEB(web[1]), .ADDRB(adb[1]), .DIB(dib[1]), .DOB(dob[1]), .VALIDB(vb[1]),
    .collision(col[1]), .collision_count(ccnt[1])
  );

  // ---------------- reference model ----------------
  int          cyc = 0;
  int          rel    [2];
  bit          in_rst [2];
  logic [15:0] mm     [2][D];
  int          qdue   [4][$];
  logic [15:0] qdat   [4][$];
  int          cq     [2][$];
  logic [15:0] edo    [4];
  logic [15:0] ecnt   [2];
  int          mode   [4] = '{0, 1, 2, 0};   // 0 write_first, 1 read_first, 2 no_change
  int          lat    [2] = '{1, 2};
  int          errors = 0;
  int          checks = 0;
  bit          chk_on = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] di, logic [1:0] we);
    logic [15:0] r;
    r = old;
    if (we[0]) r[7:0]  = di[7:0];
    if (we[1]) r[15:8] = di[15:8];
    return r;
  endfunction

  function automatic bit m_ready(int d);
    return !in_rst[d] && (cyc - rel[d] >= D);
  endfunction

  task automatic model_reset(int d);
    in_rst[d] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      qdue[2*d+p].delete();
      qdat[2*d+p].delete();
      edo[2*d+p] = '0;
    end
    cq[d].delete();
    ecnt[d] = '0;
    for (int i = 0; i < D; i++) mm[d][i] = CV;
  endtask

  task automatic model_release(int d);
    in_rst[d] = 1'b0;
    rel[d]    = cyc;
  endtask

  task automatic respond(int i, bit w, logic [15:0] pre, logic [15:0] post, int l);
    if (!w || mode[i] == 1) begin
      qdue[i].push_back(cyc + l); qdat[i].push_back(pre);
    end else if (mode[i] == 0) begin
      qdue[i].push_back(cyc + l); qdat[i].push_back(post);
    end
  endtask

  // Applies the request currently on the inputs of dut d to the model.
  task automatic model_apply(int d);
    logic [15:0] oa, ob, fin, pa, pb;
    bit ia, ib, wa, wb, co;
    if (!m_ready(d)) return;
    ia = ada[d] < D;
    ib = adb[d] < D;
    wa = ena[d] && wea[d] != 2'b00;
    wb = enb[d] && web[d] != 2'b00;
    oa = ia ? mm[d][ada[d]] : 16'h0;
    ob = ib ? mm[d][adb[d]] : 16'h0;
    co = ena[d] && enb[d] && ia && ada[d] == adb[d] && (wa || wb);
    if (co) begin
      fin = oa;
      if (wa) fin = merge(fin, dia[d], wea[d]);
      if (wb) fin = merge(fin, dib[d], web[d]);
      mm[d][ada[d]] = fin;
      cq[d].push_back(cyc + 1);
    end else begin
      if (wa && ia) mm[d][ada[d]] = merge(oa, dia[d], wea[d]);
      if (wb && ib) mm[d][adb[d]] = merge(ob, dib[d], web[d]);
    end
    pa = ia ? mm[d][ada[d]] : 16'h0;
    pb = ib ? mm[d][adb[d]] : 16'h0;
    if (ena[d]) respond(2*d,   wa, oa, pa, lat[d]);
    if (enb[d]) respond(2*d+1, wb, ob, pb, lat[d]);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    bit ev;
    bit ec;
    int i;
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d ready", d), rdy[d], m_ready(d));
        for (int p = 0; p < 2; p++) begin
          i  = 2*d + p;
          ev = 1'b0;
          if (qdue[i].size() > 0 && qdue[i][0] == cyc) begin
            ev     = 1'b1;
            edo[i] = qdat[i][0];
            void'(qdue[i].pop_front());
            void'(qdat[i].pop_front());
          end
          check($sformatf("dut%0d VALID%s", d, p ? "B" : "A"), p ? vb[d] : va[d], ev);
          check($sformatf("dut%0d DO%s", d, p ? "B" : "A"), p ? dob[d] : doa[d], edo[i]);
        end
        ec = 1'b0;
        if (cq[d].size() > 0 && cq[d][0] == cyc) begin
          ec = 1'b1;
          void'(cq[d].pop_front());
          if (ecnt[d] != 16'hFFFF) ecnt[d] = ecnt[d] + 16'd1;
        end
        check($sformatf("dut%0d collision", d), col[d], ec);
        check($sformatf("dut%0d collision_count", d), ccnt[d], ecnt[d]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(int d, bit ea, logic [1:0] wa_, logic [6:0] aa_, logic [15:0] da,
                    bit eb, logic [1:0] wb_, logic [6:0] ab_, logic [15:0] db);
    ena[d] = ea; wea[d] = wa_; ada[d] = aa_; dia[d] = da;
    enb[d] = eb; web[d] = wb_; adb[d] = ab_; dib[d] = db;
    model_apply(d);
    @(posedge CLK); #1;
    ena[d] = 1'b0; enb[d] = 1'b0; wea[d] = 2'b00; web[d] = 2'b00;
  endtask

  task automatic idle();
    @(posedge CLK); #1;
  endtask

  initial begin
    int n, r0, r1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      ena[d] = 1'b0; enb[d] = 1'b0; wea[d] = 2'b00; web[d] = 2'b00;
      ada[d] = '0; adb[d] = '0; dia[d] = '0; dib[d] = '0;
      model_reset(d);
    end
    repeat (3) @(posedge CLK);
    #1;
    chk_on = 1'b1;
    check("reset DOA", doa[0], 16'h0);
    check("reset ready", rdy[0], 1'b0);

    // Clear: dut1 gets re-reset at clear address 40.
    rst[0] = 1'b0; rst[1] = 1'b0;
    model_release(0); model_release(1);
    n = 0; r0 = -1; r1 = -1;
    while ((r0 < 0 || r1 < 0) && n < 400) begin
      @(posedge CLK); #1;
      n++;
      if (r0 < 0 && rdy[0]) r0 = n;
      if (r1 < 0 && rdy[1]) r1 = n;
      if (n == 40) begin rst[1] = 1'b1; model_reset(1); end
      if (n == 42) begin rst[1] = 1'b0; model_release(1); end
    end
    check("ready0 latency", r0, 100);
    check("ready1 latency after mid-clear reset", r1, 142);

    // dut0: clear contents
    op(0, 1, 2'b00, 7'd0, 16'h0, 1, 2'b00, 7'd57, 16'h0);
    check("clr rd0 VALIDA", va[0], 1'b1);
    check("clr rd0", doa[0], 16'hA5A5);
    check("clr rd57", dob[0], 16'hA5A5);
    op(0, 1, 2'b00, 7'd99, 16'h0, 0, 2'b00, 7'd0, 16'h0);
    check("clr rd99", doa[0], 16'hA5A5);

    // write modes
    op(0, 1, 2'b11, 7'd5, 16'h1234, 1, 2'b11, 7'd6, 16'h1234);
    check("write_first DOA", doa[0], 16'h1234);
    check("read_first DOB", dob[0], 16'hA5A5);
    op(0, 1, 2'b00, 7'd5, 16'h0, 0, 2'b00, 7'd0, 16'h0);
    check("reread 5", doa[0], 16'h1234);

    // byte lanes
    op(0, 1, 2'b01, 7'd5, 16'hFF00, 0, 2'b00, 7'd0, 16'h0);
    check("lane wf DOA", doa[0], 16'h1200);
    op(0, 1, 2'b00, 7'd5, 16'h0, 0, 2'b00, 7'd0, 16'h0);
    check("lane reread", doa[0], 16'h1200);

    // collision, both writing
    op(0, 1, 2'b11, 7'd7, 16'h1111, 1, 2'b10, 7'd7, 16'h2222);
    check("coll pulse", col[0], 1'b1);
    check("coll count 1", ccnt[0], 16'd1);
    check("coll wf DOA", doa[0], 16'h2211);
    check("coll rf DOB", dob[0], 16'hA5A5);
    idle();
    check("coll pulse end", col[0], 1'b0);
    op(0, 1, 2'b00, 7'd7, 16'h0, 0, 2'b00, 7'd0, 16'h0);
    check("coll mem", doa[0], 16'h2211);

    // collision, read vs write
    op(0, 1, 2'b00, 7'd7, 16'h0, 1, 2'b11, 7'd7, 16'h3333);
    check("rd-vs-wr DOA", doa[0], 16'h2211);
    check("coll count 2", ccnt[0], 16'd2);
    op(0, 1, 2'b00, 7'd7, 16'h0, 0, 2'b00, 7'd0, 16'h0);
    check("rd-vs-wr mem", doa[0], 16'h3333);

    // out of range
    op(0, 1, 2'b00, 7'd120, 16'h0, 1, 2'b11, 7'd110, 16'hBEEF);
    check("oor VALIDA", va[0], 1'b1);
    check("oor DOA", doa[0], 16'h0);
    op(0, 1, 2'b00, 7'd110, 16'h0, 1, 2'b11, 7'd110, 16'hBEEF);
    check("oor no collision", ccnt[0], 16'd2);

    // dut1: output register and no_change
    op(1, 1, 2'b00, 7'd3, 16'h0, 0, 2'b00, 7'd0, 16'h0);
    check("oreg early VALIDA", va[1], 1'b0);
    idle();
    check("oreg VALIDA", va[1], 1'b1);
    check("oreg DOA", doa[1], 16'hA5A5);
    op(1, 1, 2'b11, 7'd3, 16'hBEEF, 0, 2'b00, 7'd0, 16'h0);
    idle();
    check("no_change VALIDA", va[1], 1'b0);
    check("no_change DOA", doa[1], 16'hA5A5);
    op(1, 1, 2'b00, 7'd3, 16'h0, 0, 2'b00, 7'd0, 16'h0);
    idle();
    check("no_change mem", doa[1], 16'hBEEF);

    // random traffic on both instances
    for (int it = 0; it < 3000; it++) begin
      for (int d = 0; d < 2; d++) begin
        ena[d] = ($urandom_range(0, 3) != 0);
        enb[d] = ($urandom_range(0, 3) != 0);
        wea[d] = 2'($urandom_range(0, 3));
        web[d] = 2'($urandom_range(0, 3));
        ada[d] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(90, 127)) : 7'($urandom_range(0, 15));
        adb[d] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(90, 127)) : 7'($urandom_range(0, 15));
        dia[d] = 16'($urandom);
        dib[d] = 16'($urandom);
        model_apply(d);
      end
      @(posedge CLK); #1;
    end
    for (int d = 0; d < 2; d++) begin
      ena[d] = 1'b0; enb[d] = 1'b0;
    end
    repeat (4) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
